mem_sequencer: RTL and testbench

- Parametrised memory-access sequencer that replaces the ad hoc MAR/MDR/RE/WE handling of the CPU datapath with a request/response engine.
- Accepts one read or write request at a time, 1 or 2 bytes wide.
- Drives the SRAM strobes for a configurable number of wait states per byte.
- Wide requests are split into little-endian byte beats, with the second address incremented or decremented for fetch and stack use.

---
 rtl/mem_sequencer.sv | 140 ++++++++++++++
 tb/tb_mem_sequencer.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_sequencer.sv
// mem_sequencer: request/response engine that drives SRAM MAR/MDR/RE/WE.
// Accepts one 1- or 2-byte read/write at a time. Each byte beat strobes for
// WAIT_STATES+1 cycles. Wide requests become two little-endian beats with a
// one-cycle strobe gap between them; the second address is addr+1 or addr-1.
module mem_sequencer #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8,
  parameter int WAIT_STATES = 0   // 0..15 extra strobe cycles per beat
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic                req_wide,
  input  logic                req_dir,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic                rsp_valid,
  output logic [2*DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0]   rsp_last_addr,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_re,
  output logic                mem_we,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  typedef enum logic [1:0] {IDLE, STROBE, NEXT, DONE} state_e;

  // The wait counter is reloaded with this value at the start of every beat
  localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES);

  state_e              state_q;
  logic [ADDR_W-1:0]   mar_q;
  logic [ADDR_W-1:0]   mar_step_d;
  logic [ADDR_W-1:0]   last_addr_q;
  logic [DATA_W-1:0]   mdr_q;
  logic [DATA_W-1:0]   wdata_hi_q;
  logic [2*DATA_W-1:0] rdata_q;
  logic [3:0]          cnt_q;
  logic                beat_q;
  logic                write_q;
  logic                wide_q;
  logic                dir_q;
  logic                ready_q;
  logic                rsp_valid_q;
  logic                re_q;
  logic                we_q;

  // Second-beat address: one step up or down, wrapping at the address width
  assign mar_step_d = dir_q ? (mar_q - ADDR_W'(1)) : (mar_q + ADDR_W'(1));

  // Sequencer FSM; strobes and handshake are registered alongside the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mar_q       <= '0;
      mdr_q       <= '0;
      wdata_hi_q  <= '0;
      rdata_q     <= '0;
      last_addr_q <= '0;
      cnt_q       <= '0;
      beat_q      <= 1'b0;
      write_q     <= 1'b0;
      wide_q      <= 1'b0;
      dir_q       <= 1'b0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      re_q        <= 1'b0;
      we_q        <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid && ready_q) begin
            write_q    <= req_write;
            wide_q     <= req_wide;
            dir_q      <= req_dir;
            mar_q      <= req_addr;
            mdr_q      <= req_wdata[DATA_W-1:0];
            wdata_hi_q <= req_wdata[2*DATA_W-1:DATA_W];
            rdata_q    <= '0;
            cnt_q      <= WS_LOAD;
            beat_q     <= 1'b0;
            ready_q    <= 1'b0;
            re_q       <= !req_write;
            we_q       <= req_write;
            state_q    <= STROBE;
          end
        end
        STROBE: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            // Last strobe cycle of this beat: capture read data into its lane
            if (!write_q) begin
              if (beat_q) rdata_q[2*DATA_W-1:DATA_W] <= mem_rdata;
              else        rdata_q[DATA_W-1:0]        <= mem_rdata;
            end
            re_q <= 1'b0;
            we_q <= 1'b0;
            if (wide_q && !beat_q) begin
              state_q <= NEXT;
            end else begin
              last_addr_q <= mar_q;
              rsp_valid_q <= 1'b1;
              state_q     <= DONE;
            end
          end
        end
        NEXT: begin
          // Strobes stay low for this cycle so the SRAM sees a gap
          mar_q   <= mar_step_d;
          mdr_q   <= wdata_hi_q;
          beat_q  <= 1'b1;
          cnt_q   <= WS_LOAD;
          re_q    <= !write_q;
          we_q    <= write_q;
          state_q <= STROBE;
        end
        DONE: begin
          rsp_valid_q <= 1'b0;
          ready_q     <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready     = ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rdata_q;
  assign rsp_last_addr = last_addr_q;
  assign mem_addr      = mar_q;
  assign mem_re        = re_q;
  assign mem_we        = we_q;
  assign mem_wdata     = mdr_q;

endmodule

// File: tb/tb_mem_sequencer.sv
// tb_mem_sequencer: directed and randomized requests against a transaction-level
// model that predicts, per cycle, handshake, strobes, addresses and responses.
module tb_mem_sequencer;
  localparam int AW = 16;
  localparam int DW = 8;
  localparam int WS = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic          req_wide = 1'b0;
  logic          req_dir = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [15:0]   req_wdata = '0;
  logic          rsp_valid;
  logic [15:0]   rsp_rdata;
  logic [AW-1:0] rsp_last_addr;
  logic [AW-1:0] mem_addr;
  logic          mem_re;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  always #5 clk = ~clk;

  mem_sequencer #(.ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(WS)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_wide(req_wide), .req_dir(req_dir), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_last_addr(rsp_last_addr), .mem_addr(mem_addr), .mem_re(mem_re),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Unwritten locations hold a fixed address-derived pattern
  function automatic logic [7:0] init_byte(input logic [15:0] a);
    return a[7:0] ^ {a[10:8], a[15:11]} ^ 8'h5A;
  endfunction

  // SRAM: asynchronous read, written on posedge by the DUT or a bench preset
  logic [7:0]  sram     [0:65535];
  bit          sram_wr  [0:65535];
  logic        pre_en = 1'b0;
  logic [15:0] pre_addr = '0;
  logic [7:0]  pre_data = '0;

  always @(posedge clk) begin
    if (mem_we) begin
      sram[mem_addr] <= mem_wdata;
      sram_wr[mem_addr] <= 1'b1;
    end else if (pre_en) begin
      sram[pre_addr] <= pre_data;
      sram_wr[pre_addr] <= 1'b1;
    end
  end

  function automatic logic [7:0] sram_view(input logic [15:0] a);
    return sram_wr[a] ? sram[a] : init_byte(a);
  endfunction

  assign mem_rdata = sram_view(mem_addr);

  // Reference model memory
  logic [7:0] ref_mem [0:65535];
  bit         ref_wr  [0:65535];

  function automatic logic [7:0] ref_view(input logic [15:0] a);
    return ref_wr[a] ? ref_mem[a] : init_byte(a);
  endfunction

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One expected cycle of DUT behaviour
  typedef struct {
    bit          rdy;
    bit          re;
    bit          we;
    bit          vld;
    logic [15:0] addr;
    logic [7:0]  wd;
    logic [15:0] rd;
    logic [15:0] last;
  } exp_t;

  exp_t        expq[$];
  bit          chk_en = 1'b0;
  int          cyc = 0;
  int          acc_cyc = 0;
  int          obs_lat = 0;
  int          re_cycles = 0;
  int          we_cycles = 0;
  logic [15:0] hold_rd = '0;
  logic [15:0] hold_last = '0;
  logic [15:0] obs_rd = '0;
  logic [15:0] obs_last = '0;
  exp_t        e;
  logic [15:0] a0, a1;
  int          nbeats;

  // Compare process: checks every cycle, then expands any accepted request
  always @(negedge clk) begin
    if (chk_en) begin
      cyc++;
      if (!rst_n) begin
        expq.delete();
        hold_rd = '0;
        hold_last = '0;
      end
      chk("re_we_exclusive", 32'(mem_re && mem_we), 32'd0);
      if (expq.size() == 0) begin
        chk("idle_ready", 32'(req_ready), 32'd1);
        chk("idle_re", 32'(mem_re), 32'd0);
        chk("idle_we", 32'(mem_we), 32'd0);
        chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("idle_rdata_hold", 32'(rsp_rdata), 32'(hold_rd));
        chk("idle_last_hold", 32'(rsp_last_addr), 32'(hold_last));
      end else begin
        e = expq.pop_front();
        chk("busy_ready", 32'(req_ready), 32'(e.rdy));
        chk("mem_re", 32'(mem_re), 32'(e.re));
        chk("mem_we", 32'(mem_we), 32'(e.we));
        chk("rsp_valid", 32'(rsp_valid), 32'(e.vld));
        if (e.re || e.we) chk("mem_addr", 32'(mem_addr), 32'(e.addr));
        if (e.we) chk("mem_wdata", 32'(mem_wdata), 32'(e.wd));
        if (mem_re) re_cycles++;
        if (mem_we) we_cycles++;
        if (e.vld) begin
          chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rd));
          chk("rsp_last_addr", 32'(rsp_last_addr), 32'(e.last));
          hold_rd = e.rd;
          hold_last = e.last;
          obs_lat = cyc - acc_cyc;
          obs_rd = rsp_rdata;
          obs_last = rsp_last_addr;
        end
      end
      if (pre_en) begin
        ref_mem[pre_addr] = pre_data;
        ref_wr[pre_addr] = 1'b1;
      end
      if (rst_n && req_valid && req_ready) begin
        acc_cyc = cyc;
        re_cycles = 0;
        we_cycles = 0;
        a0 = req_addr;
        a1 = req_dir ? a0 - 16'd1 : a0 + 16'd1;
        nbeats = req_wide ? 2 : 1;
        for (int b = 0; b < nbeats; b++) begin
          if (b == 1) expq.push_back('{0, 0, 0, 0, 16'h0, 8'h0, 16'h0, 16'h0});
          for (int w = 0; w <= WS; w++)
            expq.push_back('{0, !req_write, req_write, 0, (b == 0) ? a0 : a1,
                             (b == 0) ? req_wdata[7:0] : req_wdata[15:8], 16'h0, 16'h0});
        end
        e = '{0, 0, 0, 1, 16'h0, 8'h0, 16'h0, req_wide ? a1 : a0};
        if (!req_write) e.rd = {req_wide ? ref_view(a1) : 8'h00, ref_view(a0)};
        expq.push_back(e);
        if (req_write) begin
          ref_mem[a0] = req_wdata[7:0];
          ref_wr[a0] = 1'b1;
          if (req_wide) begin
            ref_mem[a1] = req_wdata[15:8];
            ref_wr[a1] = 1'b1;
          end
        end
      end
    end
  end

  task automatic preset(input logic [15:0] a, input logic [7:0] d);
    pre_addr = a;
    pre_data = d;
    pre_en = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1 pre_en = 1'b0;
  endtask

  // Present a request and wait (bounded) until it is accepted
  task automatic do_req(input logic w, input logic wd, input logic dr,
                        input logic [15:0] a, input logic [15:0] d);
    bit ok;
    ok = 1'b0;
    req_write = w; req_wide = wd; req_dir = dr; req_addr = a; req_wdata = d;
    req_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (req_ready) begin
        @(posedge clk);
        #1 ok = 1'b1;
      end
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: actual=0 required=1 at %0t", $time);
    end
  endtask

  // Wait (bounded) for rsp_valid; optionally scramble req_* while busy
  task automatic wait_done(input bit garbage);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(posedge clk);
      #1;
      if (rsp_valid) ok = 1'b1;
      else if (garbage) begin
        req_valid = 1'($urandom);
        req_write = 1'($urandom);
        req_wide = 1'($urandom);
        req_dir = 1'($urandom);
        req_addr = 16'($urandom);
        req_wdata = 16'($urandom);
      end
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL done_timeout: actual=0 required=1 at %0t", $time);
    end
  endtask

  // Run one directed transaction to completion so obs_* reflect it
  task automatic txn(input logic w, input logic wd, input logic dr,
                     input logic [15:0] a, input logic [15:0] d);
    do_req(w, wd, dr, a, d);
    req_valid = 1'b0;
    wait_done(1'b0);
    @(negedge clk);
    #1;
  endtask

  initial begin
    #4_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  int acc1, acc2, nbad_mem;
  logic [15:0] ra, rd;

  initial begin
    repeat (3) @(posedge clk);
    #3;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_strobes", 32'({mem_re, mem_we}), 32'd0);
    chk("rst_mar", 32'(mem_addr), 32'd0);
    chk("rst_mdr", 32'(mem_wdata), 32'd0);
    chk("rst_rdata", 32'(rsp_rdata), 32'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    @(posedge clk);
    #1;

    // Narrow read
    preset(16'h0150, 8'h3E);
    txn(1'b0, 1'b0, 1'b0, 16'h0150, 16'h0);
    chk("nr_rdata", 32'(obs_rd), 32'h003E);
    chk("nr_last", 32'(obs_last), 32'h0150);
    chk("nr_latency", 32'(obs_lat), 32'd3);
    chk("nr_re_cycles", 32'(re_cycles), 32'd2);

    // Wide read, incrementing
    preset(16'h0100, 8'hC3);
    preset(16'h0101, 8'h50);
    txn(1'b0, 1'b1, 1'b0, 16'h0100, 16'h0);
    chk("wr_rdata", 32'(obs_rd), 32'h50C3);
    chk("wr_last", 32'(obs_last), 32'h0101);
    chk("wr_latency", 32'(obs_lat), 32'd6);
    chk("wr_re_cycles", 32'(re_cycles), 32'd4);

    // Wide write, decrementing across 0x0000
    txn(1'b1, 1'b1, 1'b1, 16'h0000, 16'hBEEF);
    chk("ww_sram0", 32'(sram_view(16'h0000)), 32'hEF);
    chk("ww_sramF", 32'(sram_view(16'hFFFF)), 32'hBE);
    chk("ww_last", 32'(obs_last), 32'hFFFF);
    chk("ww_re_cycles", 32'(re_cycles), 32'd0);
    chk("ww_we_cycles", 32'(we_cycles), 32'd4);
    chk("ww_rdata", 32'(obs_rd), 32'h0);

    // Wide read incrementing across 0xFFFF
    txn(1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h0);
    chk("wrap_rdata", 32'(obs_rd), 32'hEFBE);
    chk("wrap_last", 32'(obs_last), 32'h0000);

    // Held request: two narrow reads back to back with noise on req_* meanwhile
    do_req(1'b0, 1'b0, 1'b0, 16'h0150, 16'h0);
    acc1 = acc_cyc;
    wait_done(1'b1);
    do_req(1'b0, 1'b0, 1'b0, 16'h0101, 16'h0);
    acc2 = acc_cyc;
    req_valid = 1'b0;
    wait_done(1'b0);
    @(negedge clk);
    #1;
    chk("b2b_accept_gap", 32'(acc2 - acc1), 32'd4);
    chk("b2b_rdata", 32'(obs_rd), 32'h0050);

    // Reset asserted mid-strobe of a write; written data equals current contents
    ra = 16'h2000;
    rd = {ref_view(16'h1FFF), ref_view(16'h2000)};
    do_req(1'b1, 1'b1, 1'b1, ra, rd);
    req_valid = 1'b0;
    #2;
    chk("pre_reset_we", 32'(mem_we), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("reset_we_drop", 32'(mem_we), 32'd0);
    chk("reset_ready", 32'(req_ready), 32'd1);
    chk("reset_mar", 32'(mem_addr), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;

    // Randomized traffic with gaps, held requests and noise while busy
    for (int t = 0; t < 300; t++) begin
      logic [15:0] a;
      int sel;
      sel = int'($urandom_range(0, 7));
      a = (sel == 0) ? 16'hFFFF : (sel == 1) ? 16'h0000 : 16'($urandom);
      do_req(1'($urandom), 1'($urandom), 1'($urandom), a, 16'($urandom));
      if ($urandom_range(0, 1) == 1) wait_done(1'b1);
      else begin
        req_valid = 1'b0;
        wait_done(1'b0);
      end
      if ($urandom_range(0, 2) == 0) begin
        req_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    nbad_mem = 0;
    for (int i = 0; i < 65536; i++)
      if (sram_view(16'(i)) !== ref_view(16'(i))) nbad_mem++;
    chk("memory_image", 32'(nbad_mem), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
